// File: rtl/retire_serializer.sv
// Serialises multi-port retirement groups into one beat per retired slot towards the trace encoder.
// Groups are buffered in a FIFO; overflowing groups are dropped and counted.
module retire_serializer #(
  parameter int unsigned NrRetiredInstr = 2,
  parameter int unsigned FifoDepth      = 16,
  parameter int unsigned DropCntWidth   = 16,
  parameter int unsigned ItypeLen       = 3,
  parameter int unsigned Xlen           = 32,
  parameter int unsigned CauseLen       = 5,
  parameter int unsigned PrivLen        = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NrRetiredInstr-1:0]               iretire_i,
  input  logic [NrRetiredInstr-1:0]               ilastsize_i,
  input  logic [NrRetiredInstr-1:0][ItypeLen-1:0] itype_i,
  input  logic [NrRetiredInstr-1:0][Xlen-1:0]     iaddr_i,
  input  logic [CauseLen-1:0]                     cause_i,
  input  logic [Xlen-1:0]                         tval_i,
  input  logic [PrivLen-1:0]                      priv_i,
  input  logic                                    clear_drop_i,
  output logic                                    valid_o,
  input  logic                                    ready_i,
  output logic                                    iretire_o,
  output logic                                    ilastsize_o,
  output logic [ItypeLen-1:0]                     itype_o,
  output logic [Xlen-1:0]                         iaddr_o,
  output logic [CauseLen-1:0]                     cause_o,
  output logic [Xlen-1:0]                         tval_o,
  output logic [PrivLen-1:0]                      priv_o,
  output logic                                    last_o,
  output logic                                    full_o,
  output logic                                    overflow_o,
  output logic [DropCntWidth-1:0]                 drop_cnt_o
);

  localparam int unsigned PtrW   = $clog2(FifoDepth);
  localparam int unsigned UsageW = PtrW + 1;
  localparam int unsigned SelW   = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;

  logic [NrRetiredInstr-1:0]               mem_retire   [FifoDepth];
  logic [NrRetiredInstr-1:0]               mem_lastsize [FifoDepth];
  logic [NrRetiredInstr-1:0][ItypeLen-1:0] mem_itype    [FifoDepth];
  logic [NrRetiredInstr-1:0][Xlen-1:0]     mem_iaddr    [FifoDepth];
  logic [CauseLen-1:0]                     mem_cause    [FifoDepth];
  logic [Xlen-1:0]                         mem_tval     [FifoDepth];
  logic [PrivLen-1:0]                      mem_priv     [FifoDepth];

  logic [PtrW-1:0]           wr_ptr, rd_ptr;
  logic [UsageW-1:0]         usage;
  logic [NrRetiredInstr-1:0] served, pending;
  logic [SelW-1:0]           sel;
  logic                      full, empty, push_req, push, drop;
  logic                      valid, last, one_hot, xfer, pop;
  logic [DropCntWidth-1:0]   drop_cnt;
  logic                      overflow;

  // Fullness is taken from registered usage, so a push while full drops even if a pop happens.
  assign full     = (usage == UsageW'(FifoDepth));
  assign empty    = (usage == '0);
  assign push_req = |iretire_i;
  assign push     = push_req && !full;
  assign drop     = push_req && full;

  assign pending = mem_retire[rd_ptr] & ~served;
  assign one_hot = ((pending & (pending - NrRetiredInstr'(1))) == '0);
  assign valid   = !empty && (pending != '0);
  assign last    = valid && one_hot;
  assign xfer    = valid && ready_i;
  assign pop     = xfer && last;

  always_comb begin
    sel = '0;
    for (int i = NrRetiredInstr - 1; i >= 0; i--) begin
      if (pending[i]) sel = SelW'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_retire[wr_ptr]   <= iretire_i;
      mem_lastsize[wr_ptr] <= ilastsize_i;
      mem_itype[wr_ptr]    <= itype_i;
      mem_iaddr[wr_ptr]    <= iaddr_i;
      mem_cause[wr_ptr]    <= cause_i;
      mem_tval[wr_ptr]     <= tval_i;
      mem_priv[wr_ptr]     <= priv_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
      served <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   usage <= usage + UsageW'(1);
        2'b01:   usage <= usage - UsageW'(1);
        default: usage <= usage;
      endcase
      if (pop)       served      <= '0;
      else if (xfer) served[sel] <= 1'b1;
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_drop_i)   drop_cnt <= DropCntWidth'(1);
      else if (~&drop_cnt) drop_cnt <= drop_cnt + DropCntWidth'(1);
    end else if (clear_drop_i) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  always_comb begin
    iretire_o   = 1'b0;
    ilastsize_o = 1'b0;
    itype_o     = '0;
    iaddr_o     = '0;
    cause_o     = '0;
    tval_o      = '0;
    priv_o      = '0;
    if (valid) begin
      iretire_o   = 1'b1;
      ilastsize_o = mem_lastsize[rd_ptr][sel];
      itype_o     = mem_itype[rd_ptr][sel];
      iaddr_o     = mem_iaddr[rd_ptr][sel];
      cause_o     = mem_cause[rd_ptr];
      tval_o      = mem_tval[rd_ptr];
      priv_o      = mem_priv[rd_ptr];
    end
  end

  assign valid_o    = valid;
  assign last_o     = last;
  assign full_o     = full;
  assign overflow_o = overflow;
  assign drop_cnt_o = drop_cnt;

endmodule
